neuron_input_loader: RTL
========================

Name: neuron_input_loader

Overview:
- Upstream stage of the LIF neuron core.
- Accepts a byte-wide stream from the pin interface and assembles the full-width input vector x, weight vector w, threshold (minus_teta) and leak shift.
- Presents these to the neuron core with a one-cycle step strobe that tells the core to advance its membrane state.
- Replaces the ad-hoc "weights latched on reset, low byte only" loading with a framed, handshaked protocol.

Parameters:
- N_STAGES, 6, adder-tree depth of the neuron core.
- INPUTS, 2**N_STAGES, width of x and w (64).
- BYTES, INPUTS/8, bytes per x or w frame (8).
- OUTPUT_PRECISION, N_STAGES+2, width of minus_teta (8).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- data_in  in  8  payload byte.
- data_valid  in  1  byte present this cycle.
- data_sel  in  2  target select: 00=X, 01=W, 10=PARAM, 11=STEP.
- ready  out  1  loader accepts a byte this cycle; a transfer occurs when data_valid && ready.
- x_out  out  INPUTS  committed input spikes to the core.
- w_out  out  INPUTS  committed weights to the core.
- minus_teta_out  out  OUTPUT_PRECISION  negated threshold.
- shift_out  out  3  leak shift amount.
- step  out  1  one-cycle strobe: core consumes x_out and updates its state.
- frame_err  out  1  sticky: a partial frame was abandoned.

Behaviour:
- Reset (rst_n=0 at a clock edge) forces:
  - state=IDLE, byte_cnt=0, all staging registers cleared.
  - x_out=0, w_out=0, minus_teta_out=-5 (8'hFB), shift_out=0.
  - step=0, frame_err=0, ready=0.
- ready is registered. It rises in the first cycle after rst_n is sampled high.
- States:
  - IDLE: no partial frame.
  - COLLECT: partial frame; cur_sel latched.
  - COMMIT: exactly one cycle.
- Byte placement:
  - The k-th accepted byte of a frame (k=0..BYTES-1) is written to staging bits [8k+7:8k]. Byte 0 is the LSB.
  - byte_cnt is 0..BYTES-1 and never wraps silently.
- X and W frames:
  - IDLE + accepted byte with sel 00/01: store byte 0, latch cur_sel, byte_cnt=1, go to COLLECT.
  - COLLECT + accepted byte with the same sel: store it and increment byte_cnt.
  - On the byte with byte_cnt==BYTES-1: at that same edge the staging value plus the final byte is copied to x_out (X) or w_out (W), byte_cnt=0, go to COMMIT.
- COMMIT:
  - ready=0, so no byte is accepted.
  - step=1 if the committed frame was X; otherwise step=0.
  - Returns to IDLE next edge with ready=1.
  - Latency: last X byte accepted at edge N; x_out valid after edge N; step high in cycle N+1; next byte can be accepted at edge N+2.
- PARAM frame (sel=10), 2 bytes:
  - Byte 0: minus_teta_out <= data_in[OUTPUT_PRECISION-1:0].
  - Byte 1: shift_out <= data_in[2:0].
  - Each field is applied only when byte 1 completes the frame. Both update atomically at the same edge, then COMMIT with step=0.
- STEP (sel=10 is not involved; sel=11), single byte, data ignored:
  - From IDLE: go to COMMIT with step=1 and x_out unchanged (leak-only step).
- sel change while in COLLECT:
  - The partial frame is discarded and frame_err is set to 1.
  - The new byte is treated as byte 0 of the new target, or as a STEP if sel=11.
- x_out, w_out, minus_teta_out and shift_out never show partial frames. They change only at commit edges.
- Reset mid-frame: the partial frame is lost and committed outputs return to their reset values.
- data_valid while ready=0: the byte is ignored and not counted. The upstream must hold it.
- frame_err: sticky, cleared only by reset.
- step is never high on two consecutive cycles.

Decomposition:
- Shared package (neuron_pkg):
  - N_STAGES, INPUTS, OUTPUT_PRECISION.
  - SEL_X/SEL_W/SEL_PARAM/SEL_STEP 2-bit codes.
  - Loader state enum {IDLE, COLLECT, COMMIT}.
  - RESET_MINUS_TETA=-5.
- One natural sub-module: byte_deserializer, an 8-to-INPUTS staging register with indexed byte write and a done flag. One instance is time-shared by X and W.
- The top-level wrapper drives data_in from ui_in and data_valid/data_sel from uio_in[2:0].

Test Plan:
- Reset release:
  - Expect ready=0 in the first cycle after rst_n=1, then ready=1.
  - Expect x_out=0, w_out=0, minus_teta_out=8'hFB, shift_out=0, step=0.
- W frame: send bytes 01,02,...,08 with sel=01 back-to-back.
  - w_out=64'h0807060504030201 after the 8th edge.
  - step stays 0; ready=0 for one cycle.
- X frame: send bytes AA×8 with sel=00.
  - x_out=64'hAAAAAAAAAAAAAAAA.
  - step=1 for exactly one cycle, the cycle after the last byte.
  - A byte offered in that cycle is not accepted.
- PARAM frame: sel=10 with bytes F0, 03.
  - minus_teta_out=8'hF0 and shift_out=3, both changing at the same edge.
  - A PARAM frame with only 1 byte followed by sel=00 leaves both unchanged and sets frame_err=1.
- Abandon: 3 bytes of X, then sel=11.
  - frame_err=1, step=1 once, x_out unchanged.
  - A following full X frame commits correctly with byte 0 in bits [7:0].
- Reset mid-W-frame after 5 bytes:
  - w_out=0, frame_err=0.
  - A subsequent 8-byte W frame commits exactly those 8 bytes.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared constants, select codes and loader state type for the LIF neuron input path.
package neuron_pkg;

    localparam int N_STAGES         = 6;
    localparam int INPUTS           = 2 ** N_STAGES;
    localparam int BYTES            = INPUTS / 8;
    localparam int OUTPUT_PRECISION = N_STAGES + 2;
    localparam int CNT_W            = $clog2(BYTES);

    localparam logic [1:0] SEL_X     = 2'b00;
    localparam logic [1:0] SEL_W     = 2'b01;
    localparam logic [1:0] SEL_PARAM = 2'b10;
    localparam logic [1:0] SEL_STEP  = 2'b11;

    localparam logic [OUTPUT_PRECISION-1:0] RESET_MINUS_TETA = OUTPUT_PRECISION'(-5);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        COMMIT
    } loader_state_t;

    // PARAM frames are two bytes long; X and W frames fill the whole vector.
    function automatic logic [CNT_W-1:0] frame_last_idx(input logic [1:0] sel);
        return (sel == SEL_PARAM) ? CNT_W'(1) : CNT_W'(BYTES - 1);
    endfunction

endpackage

// File: rtl/neuron_input_loader_if.sv
// Byte-stream handshake between the pin interface (master) and the input loader (slave).
interface neuron_input_loader_if;

    logic [7:0] data_in;
    logic       data_valid;
    logic [1:0] data_sel;
    logic       ready;

    modport master (
        output data_in,
        output data_valid,
        output data_sel,
        input  ready
    );

    modport slave (
        input  data_in,
        input  data_valid,
        input  data_sel,
        output ready
    );

endinterface

// File: rtl/neuron_input_loader_byte_deserializer.sv
// Byte-indexed staging register shared by X, W and PARAM frames; self-clears when a frame completes.
module byte_deserializer
    import neuron_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              restart,
    input  logic              wr_en,
    input  logic              clr,
    input  logic [CNT_W-1:0]  idx,
    input  logic [CNT_W-1:0]  last_idx,
    input  logic [7:0]        byte_in,
    output logic [INPUTS-1:0] merged,
    output logic              done
);

    logic [INPUTS-1:0] stage;

    // merged is the staging value with the incoming byte already in place, so a
    // completing frame can be committed at the same edge as its last byte.
    always_comb begin
        merged = restart ? '0 : stage;
        merged[{idx, 3'b000} +: 8] = byte_in;
    end

    assign done = wr_en && (idx == last_idx);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage <= '0;
        end else if (clr || done) begin
            stage <= '0;
        end else if (wr_en) begin
            stage <= merged;
        end
    end

endmodule

// File: rtl/neuron_input_loader.sv
// Framed byte loader: assembles x, w, threshold and leak shift for the neuron core and issues step strobes.
module neuron_input_loader
    import neuron_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    neuron_input_loader_if.slave        bus,
    output logic [INPUTS-1:0]           x_out,
    output logic [INPUTS-1:0]           w_out,
    output logic [OUTPUT_PRECISION-1:0] minus_teta_out,
    output logic [2:0]                  shift_out,
    output logic                        step,
    output logic                        frame_err
);

    loader_state_t     state, state_n;
    logic [CNT_W-1:0]  byte_cnt, byte_cnt_n;
    logic [1:0]        cur_sel, cur_sel_n;
    logic              ready_q;
    logic              accept;
    logic              step_n;
    logic              err_set;

    logic              ds_restart;
    logic              ds_wr;
    logic              ds_clr;
    logic [CNT_W-1:0]  ds_idx;
    logic [CNT_W-1:0]  ds_last;
    logic [INPUTS-1:0] ds_merged;
    logic              ds_done;

    assign bus.ready = ready_q;
    assign accept    = bus.data_valid && ready_q;
    assign ds_last   = frame_last_idx(bus.data_sel);

    byte_deserializer u_deser (
        .clk      (clk),
        .rst_n    (rst_n),
        .restart  (ds_restart),
        .wr_en    (ds_wr),
        .clr      (ds_clr),
        .idx      (ds_idx),
        .last_idx (ds_last),
        .byte_in  (bus.data_in),
        .merged   (ds_merged),
        .done     (ds_done)
    );

    always_comb begin
        state_n    = state;
        byte_cnt_n = byte_cnt;
        cur_sel_n  = cur_sel;
        step_n     = 1'b0;
        err_set    = 1'b0;
        ds_restart = 1'b0;
        ds_wr      = 1'b0;
        ds_clr     = 1'b0;
        ds_idx     = byte_cnt;

        case (state)
            IDLE: begin
                if (accept) begin
                    if (bus.data_sel == SEL_STEP) begin
                        step_n  = 1'b1;
                        state_n = COMMIT;
                    end else begin
                        ds_restart = 1'b1;
                        ds_wr      = 1'b1;
                        ds_idx     = '0;
                        cur_sel_n  = bus.data_sel;
                        byte_cnt_n = CNT_W'(1);
                        state_n    = COLLECT;
                    end
                end
            end

            COLLECT: begin
                if (accept) begin
                    if (bus.data_sel == cur_sel) begin
                        ds_wr = 1'b1;
                        if (ds_done) begin
                            byte_cnt_n = '0;
                            step_n     = (cur_sel == SEL_X);
                            state_n    = COMMIT;
                        end else begin
                            byte_cnt_n = byte_cnt + 1'b1;
                        end
                    end else begin
                        // A select change abandons the partial frame; the new byte starts over.
                        err_set = 1'b1;
                        if (bus.data_sel == SEL_STEP) begin
                            ds_clr     = 1'b1;
                            byte_cnt_n = '0;
                            step_n     = 1'b1;
                            state_n    = COMMIT;
                        end else begin
                            ds_restart = 1'b1;
                            ds_wr      = 1'b1;
                            ds_idx     = '0;
                            cur_sel_n  = bus.data_sel;
                            byte_cnt_n = CNT_W'(1);
                        end
                    end
                end
            end

            COMMIT: begin
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            byte_cnt       <= '0;
            cur_sel        <= SEL_X;
            ready_q        <= 1'b0;
            x_out          <= '0;
            w_out          <= '0;
            minus_teta_out <= RESET_MINUS_TETA;
            shift_out      <= '0;
            step           <= 1'b0;
            frame_err      <= 1'b0;
        end else begin
            state    <= state_n;
            byte_cnt <= byte_cnt_n;
            cur_sel  <= cur_sel_n;
            ready_q  <= (state_n != COMMIT);
            step     <= step_n;
            if (err_set) begin
                frame_err <= 1'b1;
            end
            if (ds_done) begin
                case (cur_sel)
                    SEL_X: x_out <= ds_merged;
                    SEL_W: w_out <= ds_merged;
                    SEL_PARAM: begin
                        minus_teta_out <= ds_merged[OUTPUT_PRECISION-1:0];
                        shift_out      <= ds_merged[10:8];
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
